mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single external memory bus between the instruction-fetch port and the MEM-stage data port of the five-stage RISC-V pipeline. It runs one bus transaction at a time and gives the MEM stage priority over fetch. It also drives the 6-bit pipeline `stall` vector consumed by the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.

## Interface
- No parameters; widths come from the shared config (`DATA_WIDTH` = 32).
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held until `if_done` or flush.
- `if_addr` in 32: fetch address.
- `if_flush` in 1: branch redirect; discard any in-flight fetch.
- `if_data` out 32: fetched instruction, valid while `if_done`=1.
- `if_done` out 1: one-cycle fetch-complete pulse.
- `mem_req` in 1: data request, held until `mem_done`.
- `mem_we` in 1: 1 = store.
- `mem_addr` in 32: data address.
- `mem_wdata` in 32: store data.
- `mem_sel` in 4: byte enables.
- `mem_rdata` out 32: load data, valid while `mem_done`=1.
- `mem_done` out 1: one-cycle data-complete pulse.
- `id_stall_req` in 1: load-use hazard request from ID.
- `bus_req`, `bus_we` out 1 each: bus strobe and write enable.
- `bus_addr`, `bus_wdata` out 32 each: bus address and write data.
- `bus_sel` out 4: bus byte enables.
- `bus_ack` in 1: one-cycle completion from memory; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in 32: bus read data.
- `stall` out 6: bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.

## Operation
- FSM states: IDLE, MEM_WAIT, IF_WAIT, IF_DROP.
- IDLE, leaving:
  - `mem_req` & !`mem_done` → MEM_WAIT. MEM wins even if `if_req` is also high.
  - Otherwise `if_req` & !`if_done` & !`if_flush` → IF_WAIT.
- On grant, register `bus_addr`/`bus_we`/`bus_wdata`/`bus_sel` from the winner; `bus_req`=1.
- A fetch always drives `bus_we`=0 and `bus_sel`=4'hF.
- MEM_WAIT or IF_WAIT with `bus_ack`: drop `bus_req`, capture `bus_rdata` into the winner's data register, pulse the winner's done next cycle, return to IDLE.
  - Stores also pulse `mem_done`; `mem_rdata` is don't-care.
- `if_flush` while in IF_WAIT → IF_DROP.
  - Bus transaction continues; the bus is never aborted.
  - On `bus_ack` → IDLE with no `if_done` pulse and `if_data` unchanged.
- A request whose done pulse is high in the current cycle is treated as consumed. No re-grant that cycle.
- `if_data`/`mem_rdata` hold their last captured values between pulses.
- `stall` is combinational, highest priority first:
  - MEM pending (`mem_req` & !`mem_done`) → 6'b011111.
  - else `id_stall_req` → 6'b000111.
  - else IF pending (`if_req` & !`if_done` & !`if_flush`) → 6'b000011.
  - else → 6'b000000.

## Timing
- Reset: state = IDLE. `bus_req`, `bus_we`, `if_done`, `mem_done` = 0. `bus_addr`, `bus_wdata`, `if_data`, `mem_rdata` = 32'h0. `bus_sel` = 4'h0.
- Reset mid-transaction returns to IDLE immediately. A late `bus_ack` arriving in IDLE is ignored.
- Request sampled in IDLE at cycle N → `bus_req`=1 at N+1.
- `bus_ack` at cycle M → done pulse and data at M+1; `bus_req`=0 at M+1.
- Minimum latency, request to done: 2 cycles (ack at N+1).
- At least one IDLE cycle separates consecutive bus transactions.
- Bus outputs are stable from grant to ack.
- `bus_ack` in IDLE is ignored.
- `mem_req` rising during IF_WAIT waits for the fetch to finish. `stall`=011111 during the wait.

## Structure
- Shared package/config: `DATA_WIDTH`, `ZeroWord`, the FSM state encodings, and the stall-vector constants `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_MEM`.
- One sub-module: `stall_ctrl`, the pure combinational priority encoder producing `stall`. The FSM and datapath stay in the top module.

## Test plan
- **Fetch only:** `if_req`, `if_addr`=32'h100; ack two cycles after `bus_req`, `bus_rdata`=32'h00500093.
  - `bus_addr`=32'h100, `bus_sel`=4'hF.
  - `if_done` one cycle with `if_data`=32'h00500093.
  - `stall`=6'b000011 until done.
- **Simultaneous requests:** `if_req` and `mem_req` (load, addr 32'h2000) in the same cycle.
  - Data transaction goes first with `stall`=6'b011111.
  - Fetch starts only after an IDLE cycle following `mem_done`.
- **Store:** `mem_we`=1, `mem_sel`=4'b0011, `mem_wdata`=32'hDEADBEEF.
  - Bus mirrors all three; `mem_done` pulses; `if_data` unchanged.
- **Flush in flight:** `if_flush` during IF_WAIT.
  - No `if_done` after the ack; `bus_req` still held until ack.
  - Next `if_req` at 32'h200 is served normally.
- **Load-use only:** `id_stall_req`=1 with no memory requests → `stall`=6'b000111.
  - Add a pending fetch → still 6'b000111.
- **Reset mid-transaction:** `RST` in MEM_WAIT.
  - All outputs at reset values next cycle.
  - Stray `bus_ack` ignored; no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared configuration for the memory port arbiter: data width, FSM encoding
// and the pipeline stall-vector constants.
package mem_port_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    IF_WAIT  = 2'd2,
    IF_DROP  = 2'd3
  } arb_state_e;

  // Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/mem_port_arbiter_stall_ctrl.sv
// Priority encoder turning the pending-request flags into the pipeline
// stall vector; a pending data access outranks a load-use hazard, which outranks fetch.
module stall_ctrl
  import mem_port_arbiter_pkg::*;
(
  input  logic       mem_pending,
  input  logic       id_stall_req,
  input  logic       if_pending,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    if (mem_pending) begin
      stall = STALL_MEM;
    end else if (id_stall_req) begin
      stall = STALL_ID;
    end else if (if_pending) begin
      stall = STALL_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory bus between instruction fetch and the MEM stage,
// one transaction at a time with MEM priority, and drives the pipeline stall vector.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_done,

  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [3:0]            mem_sel,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,

  input  logic                  id_stall_req,

  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_sel,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,

  output logic [5:0]            stall
);

  arb_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;

  logic mem_pending;
  logic if_pending;

  // A request whose done pulse is showing this cycle has already been served.
  assign mem_pending = mem_req & ~mem_done_q;
  assign if_pending  = if_req & ~if_done_q & ~if_flush;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_pending) begin
          state_d     = MEM_WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_sel_d   = mem_sel;
        end else if (if_pending) begin
          state_d     = IF_WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = ZeroWord;
          bus_sel_d   = 4'hF;
        end
      end

      MEM_WAIT: begin
        if (bus_ack) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata;
          mem_done_d  = 1'b1;
        end
      end

      IF_WAIT: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!if_flush) begin
            if_data_d = bus_rdata;
            if_done_d = 1'b1;
          end
        end else if (if_flush) begin
          state_d = IF_DROP;
        end
      end

      // Redirected fetch: let the bus cycle finish, then discard its data.
      IF_DROP: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= ZeroWord;
      bus_wdata_q <= ZeroWord;
      bus_sel_q   <= 4'h0;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;

  stall_ctrl u_stall_ctrl (
    .mem_pending  (mem_pending),
    .id_stall_req (id_stall_req),
    .if_pending   (if_pending),
    .stall        (stall)
  );

endmodule
